mips_instr_encoder: RTL and testbench

//   Instruction encoder/loader: the encode-side counterpart of ControlUnit. Accepts

---
 rtl/mips_instr_encoder.sv | 167 ++++++++++++++++
 tb/tb_mips_instr_encoder.sv | 266 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/mips_instr_encoder.sv
// MIPS instruction encoder/loader: encodes mnemonic + fields and streams words into imem.
// Optional ENC_CHECKSUM_EN adds a running XOR checksum of every written word.
module mips_instr_encoder #(
  parameter int ADDR_W    = 6,
  parameter int DEPTH     = 64,
  parameter int BASE_ADDR = 0
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [3:0]        mnem,
  input  logic [4:0]        rs,
  input  logic [4:0]        rt,
  input  logic [4:0]        rd,
  input  logic [25:0]       imm,
  output logic              imem_we,
  output logic [ADDR_W-1:0] imem_addr,
  output logic [31:0]       imem_wdata,
  output logic              err_illegal,
  output logic              full,
  output logic [ADDR_W:0]   count
`ifdef ENC_CHECKSUM_EN
  ,
  output logic [31:0]       checksum
`endif
);

  // state | meaning
  // IDLE  | ready for a request
  // WRITE | strobing encoded word into imem
  // ERR   | pulsing err_illegal for a rejected mnemonic
  // FULL  | DEPTH words written, absorbing until reset
  typedef enum logic [1:0] {S_IDLE, S_WRITE, S_ERR, S_FULL} state_t;

  localparam logic [ADDR_W-1:0] BASE     = ADDR_W'(BASE_ADDR);
  localparam logic [ADDR_W:0]   LAST_CNT = (ADDR_W + 1)'(DEPTH - 1);

  state_t            state_q, state_d;
  logic              ready_q, ready_d;
  logic              we_q, we_d;
  logic              err_q, err_d;
  logic              full_q, full_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [ADDR_W:0]   count_q, count_d;
  logic [31:0]       wdata_q, wdata_d;
  logic [31:0]       enc_word;
  logic              enc_legal;
  logic              accept;

  always_comb begin
    enc_word  = 32'h0;
    enc_legal = 1'b1;
    case (mnem)
      4'd0:    enc_word = {6'h00, rs, rt, rd, 5'd0, 6'h20};
      4'd1:    enc_word = {6'h00, rs, rt, rd, 5'd0, 6'h22};
      4'd2:    enc_word = {6'h00, rs, rt, rd, 5'd0, 6'h24};
      4'd3:    enc_word = {6'h00, rs, rt, rd, 5'd0, 6'h25};
      4'd4:    enc_word = {6'h00, rs, rt, rd, 5'd0, 6'h2A};
      4'd5:    enc_word = {6'h23, rs, rt, imm[15:0]};
      4'd6:    enc_word = {6'h2B, rs, rt, imm[15:0]};
      4'd7:    enc_word = {6'h04, rs, rt, imm[15:0]};
      4'd8:    enc_word = {6'h08, rs, rt, imm[15:0]};
      4'd9:    enc_word = {6'h02, imm};
      4'd10:   enc_word = {6'h0C, rs, rt, imm[15:0]};
      4'd11:   enc_word = {6'h0D, rs, rt, imm[15:0]};
      default: enc_legal = 1'b0;
    endcase
  end

  assign accept = in_valid & ready_q;

  always_comb begin
    state_d = state_q;
    ready_d = ready_q;
    we_d    = 1'b0;
    err_d   = 1'b0;
    full_d  = full_q;
    addr_d  = addr_q;
    count_d = count_q;
    wdata_d = wdata_q;
    case (state_q)
      S_IDLE: begin
        if (accept) begin
          ready_d = 1'b0;
          if (enc_legal) begin
            state_d = S_WRITE;
            we_d    = 1'b1;
            wdata_d = enc_word;
          end else begin
            state_d = S_ERR;
            err_d   = 1'b1;
          end
        end
      end
      S_WRITE: begin
        addr_d  = addr_q + ADDR_W'(1);
        count_d = count_q + (ADDR_W + 1)'(1);
        if (count_q == LAST_CNT) begin
          state_d = S_FULL;
          full_d  = 1'b1;
          ready_d = 1'b0;
        end else begin
          state_d = S_IDLE;
          ready_d = 1'b1;
        end
      end
      S_ERR: begin
        state_d = S_IDLE;
        ready_d = 1'b1;
      end
      default: begin
        ready_d = 1'b0;
        full_d  = 1'b1;
      end
    endcase
  end

`ifdef ENC_CHECKSUM_EN
  logic [31:0] sum_q, sum_d;

  always_comb begin
    sum_d = sum_q;
    if (state_q == S_WRITE) sum_d = sum_q ^ wdata_q;
  end

  assign checksum = sum_q;
`endif

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= S_IDLE;
      ready_q <= 1'b1;
      we_q    <= 1'b0;
      err_q   <= 1'b0;
      full_q  <= 1'b0;
      addr_q  <= BASE;
      count_q <= '0;
      wdata_q <= 32'h0;
`ifdef ENC_CHECKSUM_EN
      sum_q   <= 32'h0;
`endif
    end else begin
      state_q <= state_d;
      ready_q <= ready_d;
      we_q    <= we_d;
      err_q   <= err_d;
      full_q  <= full_d;
      addr_q  <= addr_d;
      count_q <= count_d;
      wdata_q <= wdata_d;
`ifdef ENC_CHECKSUM_EN
      sum_q   <= sum_d;
`endif
    end
  end

  // Reset during a WRITE cycle must suppress the strobe already on the wire.
  assign imem_we     = we_q & ~reset;
  assign in_ready    = ready_q;
  assign imem_addr   = addr_q;
  assign imem_wdata  = wdata_q;
  assign err_illegal = err_q;
  assign full        = full_q;
  assign count       = count_q;

endmodule

// File: tb/tb_mips_instr_encoder.sv
// Scoreboard bench for mips_instr_encoder: directed cases plus randomized load episodes.
module tb_mips_instr_encoder;
  localparam int ADDR_W    = 6;
  localparam int DEPTH     = 4;
  localparam int BASE_ADDR = 62;
  localparam int AMOD      = 64;

  logic              clk = 1'b0;
  logic              reset = 1'b1;
  logic              in_valid = 1'b0;
  logic              in_ready;
  logic [3:0]        mnem = '0;
  logic [4:0]        rs = '0, rt = '0, rd = '0;
  logic [25:0]       imm = '0;
  logic              imem_we;
  logic [ADDR_W-1:0] imem_addr;
  logic [31:0]       imem_wdata;
  logic              err_illegal;
  logic              full;
  logic [ADDR_W:0]   count;
`ifdef ENC_CHECKSUM_EN
  logic [31:0]       checksum;
`endif

  mips_instr_encoder #(.ADDR_W(ADDR_W), .DEPTH(DEPTH), .BASE_ADDR(BASE_ADDR)) dut (
    .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(in_ready),
    .mnem(mnem), .rs(rs), .rt(rt), .rd(rd), .imm(imm),
    .imem_we(imem_we), .imem_addr(imem_addr), .imem_wdata(imem_wdata),
    .err_illegal(err_illegal), .full(full), .count(count)
`ifdef ENC_CHECKSUM_EN
    , .checksum(checksum)
`endif
  );

  always #5 clk = ~clk;

  typedef struct {
    bit          illegal;
    int          addr;
    logic [31:0] word;
  } exp_t;

  exp_t        sb[$];
  int          n_cmp = 0;
  int          n_bad = 0;
  int          mdl_acc = 0;
  int          mdl_addr = BASE_ADDR;
  int          mon_count = 0;
  logic [31:0] mon_sum = 32'h0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference encoding built from field weights rather than bit concatenation.
  function automatic logic [31:0] ref_word(input int m, input int s, input int t,
                                           input int d, input int im);
    longint op, fn, w;
    op = 0; fn = 0;
    case (m)
      0: fn = 32;  1: fn = 34;  2: fn = 36;  3: fn = 37;  4: fn = 42;
      5: op = 35;  6: op = 43;  7: op = 4;   8: op = 8;   9: op = 2;
      10: op = 12; 11: op = 13;
      default: op = 0;
    endcase
    if (m <= 4)
      w = longint'(s) * 2097152 + longint'(t) * 65536 + longint'(d) * 2048 + fn;
    else if (m == 9)
      w = op * 67108864 + (longint'(im) & 64'h3FFFFFF);
    else
      w = op * 67108864 + longint'(s) * 2097152 + longint'(t) * 65536 + (longint'(im) & 64'hFFFF);
    return 32'(w);
  endfunction

  always @(negedge clk) begin
    exp_t e;
    if (reset) begin
      mon_count = 0;
      mon_sum   = 32'h0;
    end else begin
      chk("count", 64'(count), 64'(mon_count));
      chk("full", 64'(full), 64'(mon_count >= DEPTH));
`ifdef ENC_CHECKSUM_EN
      chk("checksum", 64'(checksum), 64'(mon_sum));
`endif
      if (imem_we || err_illegal) begin
        if (sb.size() == 0) begin
          n_cmp++;
          n_bad++;
          $display("FAIL unexpected_output: we=%0b err=%0b with nothing pending", imem_we, err_illegal);
        end else begin
          e = sb.pop_front();
          chk("err_illegal", 64'(err_illegal), 64'(e.illegal));
          chk("imem_we", 64'(imem_we), 64'(!e.illegal));
          if (!e.illegal) begin
            chk("imem_addr", 64'(imem_addr), 64'(e.addr));
            chk("imem_wdata", 64'(imem_wdata), 64'(e.word));
            mon_count++;
            mon_sum = mon_sum ^ e.word;
          end
        end
      end
    end
  end

  task automatic do_reset();
    @(negedge clk);
    reset = 1'b1;
    in_valid = 1'b0;
    sb.delete();
    mdl_acc = 0;
    mdl_addr = BASE_ADDR;
    @(negedge clk);
    @(negedge clk);
    chk("rst_in_ready", 64'(in_ready), 64'd1);
    chk("rst_addr", 64'(imem_addr), 64'(BASE_ADDR));
    chk("rst_wdata", 64'(imem_wdata), 64'd0);
    chk("rst_err", 64'(err_illegal), 64'd0);
    chk("rst_full", 64'(full), 64'd0);
    chk("rst_count", 64'(count), 64'd0);
    reset = 1'b0;
    chk("rst_we", 64'(imem_we), 64'd0);
  endtask

  task automatic send(input logic [3:0] m, input logic [4:0] s, input logic [4:0] t,
                      input logic [4:0] d, input logic [25:0] im);
    int n;
    bit exp_acc;
    exp_t e;
    n = 0;
    exp_acc = (mdl_acc < DEPTH);
    @(negedge clk);
    mnem = m; rs = s; rt = t; rd = d; imm = im;
    in_valid = 1'b1;
    while (!in_ready && n < 6) begin
      @(negedge clk);
      n++;
    end
    chk("accepted", 64'(in_ready), 64'(exp_acc));
    if (!in_ready) begin
      in_valid = 1'b0;
      return;
    end
    chk("ready_wait", 64'(n), 64'd0);
    e.illegal = (m > 11);
    e.addr    = mdl_addr;
    e.word    = ref_word(int'(m), int'(s), int'(t), int'(d), int'(im));
    if (!e.illegal) begin
      mdl_addr = (mdl_addr + 1) % AMOD;
      mdl_acc++;
    end
    sb.push_back(e);
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    mnem = 4'($urandom); rs = 5'($urandom); rt = 5'($urandom);
    rd = 5'($urandom); imm = 26'($urandom);
    @(negedge clk);
    chk("ready_low_after_accept", 64'(in_ready), 64'd0);
  endtask

  task automatic send_rand();
    logic [3:0] m;
    if ($urandom_range(0, 3) == 0) m = 4'($urandom_range(12, 15));
    else m = 4'($urandom_range(0, 11));
    send(m, 5'($urandom), 5'($urandom), 5'($urandom), 26'($urandom));
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    do_reset();

    // ADD, LW, SW (wraps 63 -> 0), J, then full blocks a BEQ
    send(4'd0, 5'd1, 5'd2, 5'd3, 26'd0);
    chk("t1_word", 64'(imem_wdata), 64'h00221820);
    chk("t1_addr", 64'(imem_addr), 64'(BASE_ADDR));
    send(4'd5, 5'd0, 5'd8, 5'd0, 26'd4);
    chk("t2_lw_word", 64'(imem_wdata), 64'h8C080004);
    send(4'd6, 5'd0, 5'd9, 5'd0, 26'd8);
    chk("t2_sw_word", 64'(imem_wdata), 64'hAC090008);
    chk("t2_sw_addr_wrap", 64'(imem_addr), 64'd0);
    send(4'd9, 5'd0, 5'd0, 5'd0, 26'h0000100);
    chk("t3_j_word", 64'(imem_wdata), 64'h08000100);
    send(4'd7, 5'd1, 5'd2, 5'd0, 26'h3FFFFFF);
    @(negedge clk);
    chk("full_hold", 64'(full), 64'd1);
    chk("full_ready", 64'(in_ready), 64'd0);
    chk("full_no_strobe", 64'(imem_we), 64'd0);

    // BEQ with upper imm bits set, illegal mnemonic, then ADD at unchanged address
    do_reset();
    send(4'd7, 5'd1, 5'd2, 5'd0, 26'h3FFFFFF);
    chk("t3_beq_word", 64'(imem_wdata), 64'h1022FFFF);
    send(4'd13, 5'd1, 5'd2, 5'd3, 26'd0);
    chk("t4_err_pulse", 64'(err_illegal), 64'd1);
    chk("t4_no_strobe", 64'(imem_we), 64'd0);
    send(4'd0, 5'd1, 5'd2, 5'd3, 26'd0);
    chk("t4_add_addr", 64'(imem_addr), 64'(BASE_ADDR + 1));

    // five back-to-back legal requests; the fifth must not be taken
    do_reset();
    for (int i = 0; i < 5; i++)
      send(4'($urandom_range(0, 11)), 5'($urandom), 5'($urandom), 5'($urandom), 26'($urandom));
    chk("t5_full", 64'(full), 64'd1);
    chk("t5_count", 64'(count), 64'(DEPTH));

    // checksum of two writes
    do_reset();
    send(4'd0, 5'd1, 5'd2, 5'd3, 26'd0);
    send(4'd5, 5'd0, 5'd8, 5'd0, 26'd4);
    @(negedge clk);
`ifdef ENC_CHECKSUM_EN
    chk("t6_checksum", 64'(checksum), 64'h8C2A1824);
`endif

    // reset landing on a WRITE cycle
    do_reset();
    @(negedge clk);
    mnem = 4'd0; rs = 5'd1; rt = 5'd2; rd = 5'd3; in_valid = 1'b1;
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    chk("midwrite_we_before", 64'(imem_we), 64'd1);
    reset = 1'b1;
    #1;
    chk("midwrite_strobe_cancel", 64'(imem_we), 64'd0);
    @(posedge clk);
    #1;
    chk("midwrite_count", 64'(count), 64'd0);
    chk("midwrite_addr", 64'(imem_addr), 64'(BASE_ADDR));
    chk("midwrite_ready", 64'(in_ready), 64'd1);
    chk("midwrite_wdata", 64'(imem_wdata), 64'd0);
    @(negedge clk);
    reset = 1'b0;
    mdl_acc = 0;
    mdl_addr = BASE_ADDR;

    // randomized load episodes
    for (int ep = 0; ep < 25; ep++) begin
      int tries;
      do_reset();
      tries = 0;
      while (mdl_acc < DEPTH && tries < 40) begin
        send_rand();
        tries++;
      end
      send_rand();
    end

    @(negedge clk);
    @(negedge clk);
    chk("scoreboard_drained", 64'(sb.size()), 64'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
